// File: rtl/seq_control_unit.sv
// Hardwired multi-cycle control unit for the 32-bit bus datapath.
// Sequences fetch/decode/execute and handshakes with external memory.
module seq_control_unit #(
    parameter int          REG_SIZE    = 32,
    parameter logic [3:0]  ALU_INC     = 4'd15,
    parameter logic        ALU_MUL_SEL = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [REG_SIZE-1:0] ir_data,
    input  logic                mem_ready,
    output logic [15:0]         gpr_in,
    output logic [15:0]         gpr_out,
    output logic                hi_in,
    output logic                lo_in,
    output logic                pc_in,
    output logic                ir_in,
    output logic                z_in,
    output logic                y_in,
    output logic                mar_in,
    output logic                mdr_in,
    output logic                hi_out,
    output logic                lo_out,
    output logic                pc_out,
    output logic                z_high_out,
    output logic                z_low_out,
    output logic                mdr_out,
    output logic                inport_out,
    output logic                c_out,
    output logic                read,
    output logic [3:0]          alu_op,
    output logic                mem_rd_req,
    output logic                mem_wr_req,
    output logic                halted,
    output logic                illegal_op
);
    localparam logic [4:0] OP_ALU  = 5'h00;
    localparam logic [4:0] OP_MD   = 5'h01;
    localparam logic [4:0] OP_LD   = 5'h02;
    localparam logic [4:0] OP_ST   = 5'h03;
    localparam logic [4:0] OP_HALT = 5'h1F;

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_F1, S_FW, S_F2, S_DEC,
        S_E0, S_E1, S_E2, S_E3, S_MW, S_WW, S_HALT
    } state_t;

    state_t     state;
    logic [4:0] op_q;
    logic [3:0] ra_q, rb_q, rc_q, alu_q;

    logic [4:0] ir_op;
    logic       ir_legal;
    logic       unused_bits;

    assign ir_op       = ir_data[31:27];
    assign ir_legal    = (ir_op == OP_ALU) || (ir_op == OP_MD) || (ir_op == OP_LD) ||
                         (ir_op == OP_ST)  || (ir_op == OP_HALT);
    assign unused_bits = ^{ALU_MUL_SEL, ir_data[14:4]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            op_q  <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rc_q  <= '0;
            alu_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (run) state <= S_F0;
                S_F0:   state <= S_F1;
                S_F1:   state <= S_FW;
                S_FW:   if (mem_ready) state <= S_F2;
                S_F2:   state <= S_DEC;
                S_DEC: begin
                    op_q  <= ir_op;
                    ra_q  <= ir_data[26:23];
                    rb_q  <= ir_data[22:19];
                    rc_q  <= ir_data[18:15];
                    alu_q <= ir_data[3:0];
                    if (ir_op == OP_HALT) state <= S_HALT;
                    else if (ir_legal)    state <= S_E0;
                    else                  state <= S_F0;
                end
                S_E0:   state <= (op_q == OP_LD) ? S_MW : S_E1;
                S_E1:   state <= (op_q == OP_ST) ? S_WW : S_E2;
                S_E2:   state <= (op_q == OP_MD) ? S_E3 : S_F0;
                S_E3:   state <= S_F0;
                S_MW:   if (mem_ready) state <= S_E2;
                S_WW:   if (mem_ready) state <= S_F0;
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Controls are decoded from state and the DEC-time latches; only mdr_in
    // in the read-wait states follows mem_ready directly.
    always_comb begin
        gpr_in     = '0;
        gpr_out    = '0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        pc_in      = 1'b0;
        ir_in      = 1'b0;
        z_in       = 1'b0;
        y_in       = 1'b0;
        mar_in     = 1'b0;
        mdr_in     = 1'b0;
        hi_out     = 1'b0;
        lo_out     = 1'b0;
        pc_out     = 1'b0;
        z_high_out = 1'b0;
        z_low_out  = 1'b0;
        mdr_out    = 1'b0;
        inport_out = 1'b0;
        c_out      = 1'b0;
        read       = 1'b0;
        alu_op     = '0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        halted     = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_F0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                z_in   = 1'b1;
                alu_op = ALU_INC;
            end
            S_F1: begin
                z_low_out = 1'b1;
                pc_in     = 1'b1;
            end
            S_FW, S_MW: begin
                mem_rd_req = 1'b1;
                read       = 1'b1;
                mdr_in     = mem_ready;
            end
            S_F2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_DEC: illegal_op = !ir_legal;
            S_E0: begin
                gpr_out = 16'h1 << rb_q;
                if (op_q == OP_LD || op_q == OP_ST) mar_in = 1'b1;
                else                                y_in   = 1'b1;
            end
            S_E1: begin
                if (op_q == OP_ST) begin
                    gpr_out = 16'h1 << ra_q;
                    mdr_in  = 1'b1;
                end else begin
                    gpr_out = 16'h1 << rc_q;
                    alu_op  = alu_q;
                    z_in    = 1'b1;
                end
            end
            S_E2: begin
                if (op_q == OP_LD) begin
                    mdr_out = 1'b1;
                    gpr_in  = 16'h1 << ra_q;
                end else begin
                    z_low_out = 1'b1;
                    if (op_q == OP_MD) lo_in  = 1'b1;
                    else               gpr_in = 16'h1 << ra_q;
                end
            end
            S_E3: begin
                z_high_out = 1'b1;
                hi_in      = 1'b1;
            end
            S_WW:   mem_wr_req = 1'b1;
            S_HALT: halted     = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_seq_control_unit.sv
// Randomized bench: a per-instruction cycle schedule model predicts every
// control word, with random wait states and random mem_ready noise elsewhere.
module tb_seq_control_unit;
    logic        clk, reset, run, mem_ready;
    logic [31:0] ir_data;
    logic [15:0] gpr_in, gpr_out;
    logic hi_in, lo_in, pc_in, ir_in, z_in, y_in, mar_in, mdr_in;
    logic hi_out, lo_out, pc_out, z_high_out, z_low_out, mdr_out, inport_out, c_out;
    logic read, mem_rd_req, mem_wr_req, halted, illegal_op;
    logic [3:0] alu_op;

    typedef struct packed {
        logic [15:0] gpr_in;
        logic [15:0] gpr_out;
        logic hi_in, lo_in, pc_in, ir_in, z_in, y_in, mar_in, mdr_in;
        logic hi_out, lo_out, pc_out, z_high_out, z_low_out, mdr_out, inport_out, c_out;
        logic read;
        logic [3:0] alu_op;
        logic rd, wr, halted, illegal;
    } ctl_t;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] cur_ir;

    seq_control_unit dut (
        .clk(clk), .reset(reset), .run(run), .ir_data(ir_data), .mem_ready(mem_ready),
        .gpr_in(gpr_in), .gpr_out(gpr_out), .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in),
        .ir_in(ir_in), .z_in(z_in), .y_in(y_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .hi_out(hi_out), .lo_out(lo_out), .pc_out(pc_out), .z_high_out(z_high_out),
        .z_low_out(z_low_out), .mdr_out(mdr_out), .inport_out(inport_out), .c_out(c_out),
        .read(read), .alu_op(alu_op), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .halted(halted), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t observe();
        ctl_t o;
        o = '{gpr_in, gpr_out, hi_in, lo_in, pc_in, ir_in, z_in, y_in, mar_in, mdr_in,
              hi_out, lo_out, pc_out, z_high_out, z_low_out, mdr_out, inport_out, c_out,
              read, alu_op, mem_rd_req, mem_wr_req, halted, illegal_op};
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check at the falling edge.
    task automatic step(input string tag, input ctl_t e, input logic rdy, input logic dec);
        ctl_t o;
        int nsel;
        #1;
        mem_ready = rdy;
        ir_data   = dec ? cur_ir : $urandom();
        run       = 1'($urandom());
        @(negedge clk);
        o = observe();
        chk(tag, 64'(o), 64'(e));
        nsel = $countones({o.gpr_out, o.hi_out, o.lo_out, o.pc_out, o.z_high_out,
                           o.z_low_out, o.mdr_out, o.inport_out, o.c_out});
        chk("bus_onehot", 64'(nsel <= 1), 64'(1));
        chk("rd_wr_excl", 64'(o.rd & o.wr), 64'(0));
        @(posedge clk);
    endtask

    task automatic start_idle();
        @(posedge clk);
        #1;
        run = 1'b1;
        mem_ready = 1'($urandom());
        @(negedge clk);
        chk("idle", 64'(observe()), 64'(0));
        @(posedge clk);
    endtask

    // Expected schedule for one instruction starting at F0.
    task automatic run_instr(input logic [31:0] ir, input int wf, input int wm);
        ctl_t c;
        logic [4:0] op;
        logic [3:0] ra, rb, rc, af;
        cur_ir = ir;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15]; af = ir[3:0];

        c = '0; c.pc_out = 1; c.mar_in = 1; c.z_in = 1; c.alu_op = 4'hF;
        step("F0", c, 1'($urandom()), 0);
        c = '0; c.z_low_out = 1; c.pc_in = 1;
        step("F1", c, 1'($urandom()), 0);
        c = '0; c.rd = 1; c.read = 1;
        for (int k = 0; k < wf; k++) step("FW_wait", c, 0, 0);
        c.mdr_in = 1;
        step("FW_ready", c, 1, 0);
        c = '0; c.mdr_out = 1; c.ir_in = 1;
        step("F2", c, 1'($urandom()), 0);
        c = '0;
        c.illegal = !(op <= 5'h03 || op == 5'h1F);
        step("DEC", c, 1'($urandom()), 1);

        if (op == 5'h00 || op == 5'h01) begin
            c = '0; c.gpr_out = 16'h1 << rb; c.y_in = 1;
            step("ALU_E0", c, 1'($urandom()), 0);
            c = '0; c.gpr_out = 16'h1 << rc; c.alu_op = af; c.z_in = 1;
            step("ALU_E1", c, 1'($urandom()), 0);
            c = '0; c.z_low_out = 1;
            if (op == 5'h00) c.gpr_in = 16'h1 << ra; else c.lo_in = 1;
            step("ALU_E2", c, 1'($urandom()), 0);
            if (op == 5'h01) begin
                c = '0; c.z_high_out = 1; c.hi_in = 1;
                step("MD_E3", c, 1'($urandom()), 0);
            end
        end else if (op == 5'h02) begin
            c = '0; c.gpr_out = 16'h1 << rb; c.mar_in = 1;
            step("LD_E0", c, 1'($urandom()), 0);
            c = '0; c.rd = 1; c.read = 1;
            for (int k = 0; k < wm; k++) step("LD_wait", c, 0, 0);
            c.mdr_in = 1;
            step("LD_ready", c, 1, 0);
            c = '0; c.mdr_out = 1; c.gpr_in = 16'h1 << ra;
            step("LD_E2", c, 1'($urandom()), 0);
        end else if (op == 5'h03) begin
            c = '0; c.gpr_out = 16'h1 << rb; c.mar_in = 1;
            step("ST_E0", c, 1'($urandom()), 0);
            c = '0; c.gpr_out = 16'h1 << ra; c.mdr_in = 1;
            step("ST_E1", c, 1'($urandom()), 0);
            c = '0; c.wr = 1;
            for (int k = 0; k < wm; k++) step("ST_wait", c, 0, 0);
            step("ST_ready", c, 1, 0);
        end else if (op == 5'h1F) begin
            c = '0; c.halted = 1;
            for (int k = 0; k < 8; k++) step("HALT", c, 1'($urandom()), 0);
        end
    endtask

    initial begin
        ctl_t c;
        logic [4:0] op;
        int r;
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; ir_data = '0; cur_ir = '0;
        repeat (2) @(negedge clk);
        chk("reset", 64'(observe()), 64'(0));
        reset = 1'b0;
        start_idle();

        run_instr(32'h0090_8002, 0, 0);
        run_instr({5'h02, 4'd3, 4'd7, 4'd0, 11'd0, 4'd0}, 0, 3);
        run_instr({5'h03, 4'd5, 4'd2, 4'd0, 11'd0, 4'd0}, 1, 2);
        run_instr({5'h01, 4'd4, 4'd9, 4'd12, 11'd0, 4'd6}, 2, 0);
        run_instr({5'h0A, 27'h555_1234}, 0, 0);
        run_instr({5'h00, 4'd7, 4'd7, 4'd7, 11'd0, 4'd9}, 0, 0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 8) ? 5'(r / 2) : 5'($urandom_range(4, 30));
            run_instr({op, 4'($urandom()), 4'($urandom()), 4'($urandom()),
                       11'($urandom()), 4'($urandom())},
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end
        run_instr({5'h1F, 27'h0}, 0, 0);

        // Reset out of HALT, then abort a pending fetch read.
        #1 reset = 1'b1;
        #1 chk("reset_halt", 64'(observe()), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        start_idle();
        cur_ir = 32'h0;
        c = '0; c.pc_out = 1; c.mar_in = 1; c.z_in = 1; c.alu_op = 4'hF;
        step("F0", c, 1'b1, 0);
        c = '0; c.z_low_out = 1; c.pc_in = 1;
        step("F1", c, 1'b1, 0);
        c = '0; c.rd = 1; c.read = 1;
        step("FW_wait", c, 0, 0);
        #1 mem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("reset_mid_fw", 64'(observe()), 64'(0));
        chk("reset_rd_req", 64'(mem_rd_req), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
